// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
//   start  : request, taken only while the unit is idle and flush is low
//   funct3 : RV32M operation select
//   op_a   : rs1 value (dividend / multiplicand)
//   op_b   : rs2 value (divisor / multiplier)
//   flush  : synchronous abort of any in-flight operation
//   busy   : operation in flight (stall request to hazard control)
//   done   : one-cycle pulse, result valid
//   result : writeback value, held until the next accepted start
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed latency.
// One radix-2 step per cycle for DATA_WIDTH cycles: shift-add for the
// multiplies, restoring shift-subtract for the divides. Operands are
// reduced to magnitudes at accept time and the sign is re-applied when the
// result is registered, so the iteration itself is purely unsigned.
// Ports:
//   clk : clock, rising-edge state updates
//   rst : synchronous active-high reset
//   bus : muldiv_unit_if slave (start/funct3/op_a/op_b/flush in,
//         busy/done/result out)
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic               busy_c, done_c;
  logic               accept, last_step;
  logic [CNT_W-1:0]   cnt_p1;
  logic [W-1:0]       result_q;

  logic               a_sgn_c, b_sgn_c, neg_c, div0_c, ovf_c;
  logic [W-1:0]       a_mag_c, b_mag_c;

  logic [2:0]         op_p1;
  logic [W-1:0]       opnd_p1;
  logic [W-1:0]       dvd_p1;
  logic [2*W-1:0]     acc_p1;
  logic [2*W-1:0]     acc_nxt;
  logic               neg_p1, div0_p1, ovf_p1;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    logic signed [W-1:0] xs;
    xs = $signed(x);
    return en ? $unsigned(-xs) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
    logic signed [2*W-1:0] xs;
    xs = $signed(x);
    return en ? $unsigned(-xs) : x;
  endfunction

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] acc,
                                          input logic [W-1:0]   opnd,
                                          input logic           is_div);
    logic [W:0] sum;
    logic [W:0] rsh;
    logic [W:0] diff;
    if (!is_div) begin
      sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
      return {sum, acc[W-1:1]};
    end else begin
      rsh  = {acc[2*W-1:W], acc[W-1]};
      diff = rsh - {1'b0, opnd};
      // The kept remainder is always below the divisor, so W bits suffice.
      if (!diff[W]) return {diff[W-1:0], acc[W-2:0], 1'b1};
      else          return {rsh[W-1:0],  acc[W-2:0], 1'b0};
    end
  endfunction

  function automatic logic [W-1:0] finalize(input logic [2:0]     f,
                                            input logic [2*W-1:0] acc,
                                            input logic           neg,
                                            input logic           div0,
                                            input logic           ovf,
                                            input logic [W-1:0]   dvd);
    logic [2*W-1:0] prod;
    if (!f[2]) begin
      prod = neg_2w(acc, neg);
      return (f[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end
    if (div0) return f[1] ? dvd : {W{1'b1}};
    if (ovf)  return f[1] ? {W{1'b0}} : dvd;
    return f[1] ? neg_w(acc[2*W-1:W], neg) : neg_w(acc[W-1:0], neg);
  endfunction

  assign accept    = bus.start & ~bus.flush & (state == IDLE);
  assign last_step = (cnt_p1 == CNT_W'(W - 1));
  assign acc_nxt   = step(acc_p1, opnd_p1, op_p1[2]);

  always_comb begin
    a_sgn_c = 1'b0;
    b_sgn_c = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn_c = bus.op_a[W-1];
        b_sgn_c = bus.op_b[W-1];
      end
      3'b010:  a_sgn_c = bus.op_a[W-1];
      default: ;
    endcase
  end

  assign a_mag_c = neg_w(bus.op_a, a_sgn_c);
  assign b_mag_c = neg_w(bus.op_b, b_sgn_c);
  // REM follows the dividend sign; DIV and the multiplies follow sign xor.
  assign neg_c   = (bus.funct3 == 3'b110) ? a_sgn_c : (a_sgn_c ^ b_sgn_c);
  assign div0_c  = bus.funct3[2] & (bus.op_b == {W{1'b0}});
  assign ovf_c   = bus.funct3[2] & ~bus.funct3[0] &
                   (bus.op_a == {1'b1, {(W-1){1'b0}}}) & (bus.op_b == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = (state != IDLE);
    done_c    = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (bus.flush)      state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control: iteration counter and architectural result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1   <= '0;
      result_q <= '0;
    end else begin
      if (accept)             cnt_p1 <= '0;
      else if (state == CALC) cnt_p1 <= cnt_p1 + CNT_W'(1);
      if (state == CALC && last_step && !bus.flush)
        result_q <= finalize(op_p1, acc_nxt, neg_p1, div0_p1, ovf_p1, dvd_p1);
    end
  end

  // ---- datapath: operands captured at accept, accumulator iterates in CALC ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1   <= bus.funct3;
      opnd_p1 <= bus.funct3[2] ? b_mag_c : a_mag_c;
      acc_p1  <= {{W{1'b0}}, (bus.funct3[2] ? a_mag_c : b_mag_c)};
      neg_p1  <= neg_c;
      div0_p1 <= div0_c;
      ovf_p1  <= ovf_c;
      dvd_p1  <= bus.op_a;
    end else if (state == CALC) begin
      acc_p1  <= acc_nxt;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random testbench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(W)) bus ();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference using native wide arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0]        ua, ubu, pu;
    logic signed [31:0] a32, b32, r32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ua = {32'b0, a};
    ubu = {32'b0, b};
    a32 = a;
    b32 = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = ua * ubu; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r32 = a32 / b32; return r32;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        r32 = a32 % b32; return r32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // mode 0: plain; 1: stray start in cycles 5 and 33; 2: flush in the DONE cycle.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expv, input int mode);
    int guard = 0;
    logic [W-1:0] e;
    while (bus.busy !== 1'b0 && guard < 100) begin tick; guard++; end
    if (guard >= 100) chk1("idle_wait_timeout", bus.busy, 1'b0);
    bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    exp_q.push_back(expv);
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      chk1($sformatf("busy_f%0d_c%0d", f, c), bus.busy, 1'b1);
      chk1($sformatf("done_f%0d_c%0d", f, c), bus.done, c == 33);
      if (c == 33) begin
        e = exp_q.pop_front();
        chk($sformatf("result_f%0d_a%h_b%h", f, a, b), bus.result, e);
        last_res = e;
      end
      bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom);
      if (mode == 1) bus.start = (c == 5 || c == 33);
      if (mode == 2) bus.flush = (c == 33);
      tick;
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    chk1($sformatf("busy_end_f%0d", f), bus.busy, 1'b0);
    chk1($sformatf("done_end_f%0d", f), bus.done, 1'b0);
    chk($sformatf("result_hold_f%0d", f), bus.result, last_res);
  endtask

  initial begin
    int nd;
    logic [2:0] rf;
    logic [W-1:0] ra, rb;
    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0;
    last_res = '0;
    repeat (2) tick;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, '0);
    rst = 1'b0;
    tick;
    chk1("post_rst_busy", bus.busy, 1'b0);

    // Basic multiply and high-half multiplies issued back to back.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Divides, including stray starts and a flush in the DONE cycle.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 2);

    // Divide by zero and signed overflow.
    run_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd100, 32'd0, 32'd100, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Flush in cycle 10 of a DIV, then a fresh start in cycle 11.
    bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk1($sformatf("flush_busy_c%0d", c), bus.busy, 1'b1);
      chk1($sformatf("flush_done_c%0d", c), bus.done, 1'b0);
      if (c == 10) bus.flush = 1'b1;
      tick;
    end
    bus.flush = 1'b0;
    chk1("flush_busy_c11", bus.busy, 1'b0);
    chk1("flush_done_c11", bus.done, 1'b0);
    chk("flush_result_kept", bus.result, last_res);
    run_op(3'd5, 32'd1000, 32'd10, 32'd100, 0);

    // Random operations against the reference.
    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 3) rb = '0;
      if (i % 4 == 2) ra = 32'h8000_0000 | 32'($urandom_range(0, 3));
      run_op(rf, ra, rb, ref_res(rf, ra, rb), 0);
    end

    // Reset in cycle 20 of a MUL.
    bus.funct3 = 3'd0; bus.op_a = 32'd123; bus.op_b = 32'd456; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_done", bus.done, 1'b0);
    chk("midrst_result", bus.result, '0);
    last_res = '0;
    nd = 0;
    repeat (40) begin
      if (bus.done === 1'b1) nd++;
      tick;
    end
    chk("midrst_no_done", W'(nd), '0);

    // rst with start, then flush with start: neither accepted.
    rst = 1'b1; bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd5;
    tick;
    rst = 1'b0; bus.start = 1'b0;
    chk1("rst_start_busy", bus.busy, 1'b0);
    tick;
    chk1("rst_start_busy2", bus.busy, 1'b0);
    bus.flush = 1'b1; bus.start = 1'b1;
    tick;
    bus.flush = 1'b0; bus.start = 1'b0;
    chk1("flush_start_busy", bus.busy, 1'b0);
    tick;
    chk1("flush_start_busy2", bus.busy, 1'b0);
    chk("flush_start_result", bus.result, last_res);

    run_op(3'd0, 32'd6, 32'd7, 32'd42, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It consumes the two source operands read from the register file (RD1/RD2) and produces a 32-bit result for writeback. A start/busy/done handshake lets hazard control stall the pipeline while the unit runs. Fixed, data-independent latency keeps stall logic simple.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only in a cycle where busy=0 and flush=0
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_WIDTH  rs1 value (RD1); dividend / multiplicand
op_b  input  DATA_WIDTH  rs2 value (RD2); divisor / multiplier
flush  input  1  synchronous abort (branch mispredict / pipeline flush)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid that cycle
result  output  DATA_WIDTH  result; held until next accepted start

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, iteration counter=0. Reset mid-operation discards the operation; no done.
- States: IDLE -> CALC -> DONE -> IDLE. busy = (state != IDLE). done = (state == DONE).
- Accept: start=1, busy=0, flush=0 at edge of cycle 0 -> capture funct3, op_a, op_b; record result sign; take magnitudes for signed operands; state CALC, counter=0.
- Timing: start in cycle 0 -> busy high in cycles 1..33, done high only in cycle 33, busy low in cycle 34. Back-to-back: start may be asserted in cycle 34 at the earliest (busy=0 there). start during DONE is ignored.
- CALC: one radix-2 step per cycle for DATA_WIDTH cycles (cycles 1..32). Multiply: shift-add into a 2*DATA_WIDTH accumulator. Divide: restoring shift-subtract producing quotient and remainder magnitudes. After the last step the counter wraps and state goes to DONE.
- Result is registered on the CALC->DONE edge and is valid in cycle 33. It stays stable until the edge that accepts the next start.
- Sign rules:
  - MUL: low half of the product.
  - MULH: signed x signed, high half.
  - MULHSU: signed op_a x unsigned op_b, high half.
  - MULHU: unsigned x unsigned, high half.
  - Signed product is negated as a 64-bit value when operand signs differ.
  - DIV quotient is negative iff operand signs differ; REM takes the sign of the dividend.
- Divide by zero (op_b=0), fixed latency: DIV/DIVU quotient = all ones; REM/REMU = op_a.
- Signed overflow (DIV, op_a=0x80000000, op_b=0xFFFFFFFF): quotient = 0x80000000; REM = 0. Same latency.
- Special cases are detected at accept time and override the datapath result at DONE.
- flush:
  - Any cycle with busy=1: next state IDLE, no done, result unchanged from previous value.
  - flush and start together while idle: start is not accepted.
  - flush during the DONE cycle: done still asserts that cycle (the op has completed); flush only blocks future acceptance that cycle.
- Inputs op_a/op_b/funct3 are don't-care after accept; changing them mid-operation has no effect.
- rst has priority over flush, and flush over start.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3), start in cycle 0 -> busy=1 in cycles 1..33; done only in cycle 33; result=0xFFFFFFEB; busy=0 in cycle 34.
2. High-half multiplies, one at a time, with back-to-back starts each issued in the first cycle busy=0:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
3. Signed divide, op_a=0xFFFFFFF9 (-7), op_b=2:
   - DIV -> 0xFFFFFFFD
   - REM -> 0xFFFFFFFF
   - DIVU 100/7 -> 14; REMU 100/7 -> 2
4. Special cases, each done in cycle 33:
   - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0
5. Flush/start interaction:
   - Start DIV in cycle 0, flush=1 in cycle 10 -> busy=0 from cycle 11, no done pulse, result keeps prior value.
   - New start in cycle 11 completes with done in cycle 44.
   - start asserted in cycle 5 of a running op is ignored.
6. Reset and simultaneous control:
   - rst=1 in cycle 20 of a MUL -> cycle 21: busy=0, done=0, result=0; no done ever issued for that op.
   - rst=1 with start=1 -> not accepted.
   - flush=1 with start=1 while idle -> not accepted; busy stays 0.
